// File: rtl/fpgano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpgano_pkg
//  Description : Shared definitions for the rhythm-game sequencer: default
//                widths, countdown length, FSM state encoding and a helper
//                that maps a zero note length onto one beat.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpgano_pkg;

  localparam int DEFAULT_FRAME_W         = 8;
  localparam int DEFAULT_COUNTDOWN_BEATS = 3;

  localparam int         STATE_W      = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // A note never lasts less than one beat, so a zero length counts as one.
  function automatic logic [3:0] effective_hold(input logic [3:0] hold);
    return (hold == 4'd0) ? 4'd1 : hold;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                clr   - synchronous clear (wins over inc)
//                inc   - count enable
//                count - current tally
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Rhythm-game sequencer. Runs a countdown after start, then
//                scores one key sample per beat, steps through the song's
//                frames according to each note's hold length, and supports
//                pause/resume and abort.
//  Ports       : CLOCK_50    - system clock
//                reset_n     - asynchronous active-low reset
//                beat_tick   - one-cycle beat pulse
//                start_req / pause_req / abort_req - one-cycle requests
//                song_len    - frames in the song (0 behaves as 1)
//                hold_len    - beats of the note at the current frame
//                correct_key - pressed key matches current note
//                frame       - current frame index
//                running / paused / done / counting - one-hot state flags
//                frame_adv / hit / miss - one-cycle event pulses
//                hits / misses - saturating score tallies
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import fpgano_pkg::*;
#(
  parameter int FRAME_W         = DEFAULT_FRAME_W,
  parameter int COUNTDOWN_BEATS = DEFAULT_COUNTDOWN_BEATS,
  parameter int CNT_W           = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               beat_tick,
  input  logic               start_req,
  input  logic               pause_req,
  input  logic               abort_req,
  input  logic [FRAME_W-1:0] song_len,
  input  logic [3:0]         hold_len,
  input  logic               correct_key,
  output logic [FRAME_W-1:0] frame,
  output logic               running,
  output logic               paused,
  output logic               done,
  output logic               counting,
  output logic               frame_adv,
  output logic               hit,
  output logic               miss,
  output logic [CNT_W-1:0]   hits,
  output logic [CNT_W-1:0]   misses
);

  localparam int CD_W = (COUNTDOWN_BEATS < 2) ? 1 : $clog2(COUNTDOWN_BEATS + 1);

  // Reset asserts immediately but releases through two flops so the first
  // state change happens well clear of the deassertion edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [3:0]         r_beat_in_note, w_beat_nxt;
  logic [CD_W-1:0]    r_countdown, w_cd_nxt;
  logic               r_frame_adv, w_adv_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_miss, w_miss_nxt;
  logic               w_clr_cnt;
  logic [FRAME_W-1:0] w_last_frame;
  logic [4:0]         w_beat_inc;
  logic               r_running, r_paused, r_done, r_counting;

  assign w_last_frame = (song_len == '0) ? '0 : song_len - 1'b1;
  assign w_beat_inc   = {1'b0, r_beat_in_note} + 5'd1;

  // Priority abort > pause > start > tick. A request the current state does
  // not act on does not block a lower-priority one.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_beat_nxt  = r_beat_in_note;
    w_cd_nxt    = r_countdown;
    w_adv_nxt   = 1'b0;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    w_clr_cnt   = 1'b0;
    if (abort_req) begin
      w_state_nxt = ST_IDLE;
      w_frame_nxt = '0;
      w_beat_nxt  = '0;
      w_cd_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            w_state_nxt = ST_COUNTDOWN;
            w_cd_nxt    = CD_W'(COUNTDOWN_BEATS);
            w_frame_nxt = '0;
            w_beat_nxt  = '0;
            w_clr_cnt   = 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (beat_tick) begin
            if (r_countdown <= CD_W'(1)) begin
              w_state_nxt = ST_PLAY;
              w_cd_nxt    = '0;
            end else begin
              w_cd_nxt = r_countdown - 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (pause_req) begin
            w_state_nxt = ST_PAUSED;
          end else if (beat_tick) begin
            w_hit_nxt  = correct_key;
            w_miss_nxt = !correct_key;
            if (w_beat_inc >= {1'b0, effective_hold(hold_len)}) begin
              w_beat_nxt = '0;
              // Leaving the last frame ends the song; frame stays put.
              if (r_frame >= w_last_frame) begin
                w_state_nxt = ST_DONE;
              end else begin
                w_frame_nxt = r_frame + 1'b1;
                w_adv_nxt   = 1'b1;
              end
            end else begin
              w_beat_nxt = w_beat_inc[3:0];
            end
          end
        end
        ST_PAUSED: begin
          if (pause_req) w_state_nxt = ST_PLAY;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= ST_IDLE;
      r_frame        <= '0;
      r_beat_in_note <= '0;
      r_countdown    <= '0;
      r_frame_adv    <= 1'b0;
      r_hit          <= 1'b0;
      r_miss         <= 1'b0;
      r_running      <= 1'b0;
      r_paused       <= 1'b0;
      r_done         <= 1'b0;
      r_counting     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame        <= w_frame_nxt;
      r_beat_in_note <= w_beat_nxt;
      r_countdown    <= w_cd_nxt;
      r_frame_adv    <= w_adv_nxt;
      r_hit          <= w_hit_nxt;
      r_miss         <= w_miss_nxt;
      r_running      <= (w_state_nxt == ST_PLAY);
      r_paused       <= (w_state_nxt == ST_PAUSED);
      r_done         <= (w_state_nxt == ST_DONE);
      r_counting     <= (w_state_nxt == ST_COUNTDOWN);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_hits (
    .clk   (CLOCK_50),
    .rst_n (w_rst_n),
    .clr   (w_clr_cnt),
    .inc   (w_hit_nxt),
    .count (hits)
  );

  sat_counter #(.WIDTH(CNT_W)) u_misses (
    .clk   (CLOCK_50),
    .rst_n (w_rst_n),
    .clr   (w_clr_cnt),
    .inc   (w_miss_nxt),
    .count (misses)
  );

  assign frame     = r_frame;
  assign running   = r_running;
  assign paused    = r_paused;
  assign done      = r_done;
  assign counting  = r_counting;
  assign frame_adv = r_frame_adv;
  assign hit       = r_hit;
  assign miss      = r_miss;

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter FRAME_W, default 8, SHALL set the width of the frame index and of song_len.
REQ-002 Parameter COUNTDOWN_BEATS, default 3, SHALL set the number of beats between start and the first scored frame.
REQ-003 Parameter CNT_W, default 10, SHALL set the width of the hit and miss counters.
REQ-004 CLOCK_50  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 beat_tick  in  1  SHALL be a one-cycle pulse per game beat.
REQ-007 start_req, pause_req, abort_req  in  1 each  SHALL be one-cycle request pulses, already debounced.
REQ-008 song_len  in  FRAME_W  SHALL be the number of frames in the song.
REQ-009 hold_len  in  4  SHALL be the beat count of the current frame's note, valid combinationally from frame.
REQ-010 correct_key  in  1  SHALL be high when the pressed key matches the current note.
REQ-011 frame  out  FRAME_W  SHALL be the current frame index.
REQ-012 running, paused, done, counting  out  1 each  SHALL be one-hot state flags; all low means IDLE.
REQ-013 frame_adv, hit, miss  out  1 each  SHALL be one-cycle pulses.
REQ-014 hits, misses  out  CNT_W each  SHALL be saturating tallies.

Function
REQ-015 States: IDLE, COUNTDOWN, PLAY, PAUSED, DONE.
REQ-016 IDLE or DONE + start_req -> COUNTDOWN; load countdown to COUNTDOWN_BEATS; clear frame, beat_in_note, hits and misses.
REQ-017 COUNTDOWN: each beat_tick decrements; the tick that brings the count to 0 -> PLAY. No scoring.
REQ-018 PLAY, each beat_tick: sample correct_key; pulse hit if high, else miss, in the cycle after the tick; increment the matching counter, saturating at all-ones.
REQ-019 On the same tick, beat_in_note SHALL increment; when the new value >= max(hold_len,1), clear beat_in_note, pulse frame_adv, and increment frame.
REQ-020 A tick that advances out of frame song_len-1 SHALL go to DONE with frame held at song_len-1; song_len=0 SHALL be treated as 1.
REQ-021 PLAY + pause_req -> PAUSED; PAUSED + pause_req -> PLAY; in PAUSED, ticks are ignored and frame, beat_in_note and counters are frozen.
REQ-022 pause_req in IDLE, COUNTDOWN or DONE SHALL be ignored; start_req in COUNTDOWN, PLAY or PAUSED SHALL be ignored.
REQ-023 abort_req in any state SHALL go to IDLE at the next edge, clear frame and beat_in_note, and retain hits and misses.
REQ-024 Same-cycle priority SHALL be abort_req > pause_req > start_req > beat_tick; a lower-priority event is dropped, not queued.
REQ-025 All outputs SHALL be registered; a state flag changes one cycle after its causing event.

Reset
REQ-026 While reset_n is low: state=IDLE; frame, beat_in_note, countdown, hits and misses = 0; all flags and pulses = 0.
REQ-027 Reset mid-game SHALL take effect immediately and asynchronously; release SHALL be synchronised, with the first transition no earlier than the second edge after deassertion.

Structure
REQ-028 The state encoding, COUNTDOWN_BEATS and the FRAME_W default SHALL live in the shared package fpgano_pkg.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice (hits, misses); the FSM stays in game_sequencer.

Verification
REQ-030 Countdown: start_req, then 3 beat_ticks -> counting for ticks 1-2, running after tick 3, frame=0, no hit/miss pulses.
REQ-031 Song: song_len=4, hold_len=1,2,1,3, correct_key always high -> frame_adv after ticks 1, 3, 4; done after tick 7; hits=7, misses=0.
REQ-032 Pause: pause_req in the same cycle as beat_tick in PLAY -> paused=1, tick dropped, frame unchanged; 5 ticks while paused -> no change; second pause_req -> running=1.
REQ-033 Saturation: CNT_W=3, 9 ticks with correct_key low -> misses stops at 7; miss pulses still emitted.
REQ-034 Abort/reset: abort_req at frame 2 -> IDLE, frame=0, hits retained; reset_n low at frame 2 -> all outputs 0 immediately.
REQ-035 Edge cases: song_len=0 -> DONE after first PLAY frame; hold_len=0 -> treated as 1 beat; start_req in DONE -> COUNTDOWN with counters cleared.
